// File: rtl/multicycle_pc_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing for the PC datapath.
// Define MCPC_PERF_EN to add the retired_cnt / stall_cnt performance counters.
module multicycle_pc_ctrl #(
    parameter int OPW    = 5,
    parameter int PERF_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           cond_true,
    input  logic           mem_ack,
    output logic           mem_req,
    output logic           mem_we,
    output logic           ir_we,
    output logic           pc_we,
    output logic           branch,
    output logic [1:0]     jump,
    output logic           rf_we,
    output logic [1:0]     wb_sel,
    output logic           halted,
    output logic           illegal
`ifdef MCPC_PERF_EN
    ,
    output logic [PERF_W-1:0] retired_cnt,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0] w_op;
    logic       w_is_st;
    state_t     w_retire;

    assign w_op     = opcode[OPW-1 -: 5];
    assign w_is_st  = (w_op == 5'b01001);
    assign w_retire = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        branch  = 1'b0;
        jump    = 2'b00;
        rf_we   = 1'b0;
        wb_sel  = 2'b00;
        halted  = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                // Everything except LD/ST/HALT retires here with a single pc_we.
                pc_we  = 1'b1;
                w_next = w_retire;
                casez (w_op)
                    5'b00???: rf_we = 1'b1;
                    5'b01000,
                    5'b01001: begin
                        pc_we  = 1'b0;
                        w_next = S_MEM;
                    end
                    5'b01010: branch = cond_true;
                    5'b01011: begin
                        branch = 1'b1;
                        rf_we  = 1'b1;
                        wb_sel = 2'b10;
                    end
                    5'b01100: jump = 2'b01;
                    5'b01101: begin
                        jump   = 2'b10;
                        rf_we  = 1'b1;
                        wb_sel = 2'b10;
                    end
                    5'b01110: jump = 2'b11;
                    5'b01111: begin
                        pc_we  = 1'b0;
                        w_next = S_HALT;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_st;
                if (mem_ack) begin
                    if (w_is_st) begin
                        pc_we  = 1'b1;
                        w_next = w_retire;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = 2'b01;
                pc_we  = 1'b1;
                w_next = w_retire;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef MCPC_PERF_EN
    logic [PERF_W-1:0] r_retired_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    // Counters wrap naturally at 2^PERF_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (pc_we) r_retired_cnt <= r_retired_cnt + 1'b1;
            if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ack)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

endmodule
